stream_width_downsizer: RTL and testbench

//  Downstream consumer of a relay station's FWFT read port. It splits each
//  IN_WIDTH word into RATIO narrower beats and writes them into a downstream

---
 rtl/stream_width_downsizer.sv | 72 +++++++
 tb/tb_stream_width_downsizer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_width_downsizer.sv
// Splits each IN_WIDTH FWFT word into RATIO narrow beats, one beat per cycle; beat 0 is on the output the cycle after the pop.
// Backpressure: if_full_n low freezes buf/cnt/if_din; the next word is popped only on the edge that accepts the current word's last beat.
module stream_width_downsizer #(
    parameter int  IN_WIDTH  = 64,
    parameter int  RATIO     = 2,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int OUT_WIDTH = IN_WIDTH / RATIO,
    localparam int CNT_W     = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_empty_n,
    output logic                 if_read,
    input  logic [IN_WIDTH-1:0]  if_dout,
    input  logic                 if_full_n,
    output logic                 if_write,
    output logic [OUT_WIDTH-1:0] if_din
);
    typedef enum logic {ST_EMPTY = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    state_t              r_state, w_state_nxt;
    logic [IN_WIDTH-1:0] r_buf, w_buf_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_sel;
    logic                w_buf_valid, w_fire, w_last;

    assign w_buf_valid = (r_state == ST_BUSY);
    assign w_fire      = w_buf_valid & if_full_n;
    assign w_last      = (r_cnt == LAST_CNT);
    assign if_read     = reset_n & if_empty_n & (~w_buf_valid | (w_fire & w_last));
    assign if_write    = w_buf_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A pop always reloads; otherwise an accepted beat advances or retires the word.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        if (if_read) begin
            w_state_nxt = ST_BUSY;
            w_buf_nxt   = if_dout;
            w_cnt_nxt   = '0;
        end else if (w_fire) begin
            if (w_last) begin
                w_state_nxt = ST_EMPTY;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt   = r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_sel  = LSB_FIRST ? r_cnt : (LAST_CNT - r_cnt);
        if_din = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (w_sel == CNT_W'(i)) if_din = r_buf[i*OUT_WIDTH +: OUT_WIDTH];
        end
    end
endmodule

// File: tb/tb_stream_width_downsizer.sv
// Directed checks on a 64->32 LSB-first instance plus a randomized 48->16 MS-first scoreboard run.
module tb_stream_width_downsizer;
    localparam logic [63:0] W1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] W2 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam int N_RAND = 2000;
    localparam int N_CONT = 12;

    logic        clk, rst_n;
    logic        empty_n, rd, full_n, wr;
    logic [63:0] dout;
    logic [31:0] din;
    logic        empty3, rd3, full3, wr3;
    logic [47:0] dout3;
    logic [15:0] din3;

    int n_assert = 0;
    int n_fail   = 0;

    stream_width_downsizer #(.IN_WIDTH(64), .RATIO(2), .LSB_FIRST(1'b1)) u_dut (
        .clk(clk), .reset_n(rst_n), .if_empty_n(empty_n), .if_read(rd),
        .if_dout(dout), .if_full_n(full_n), .if_write(wr), .if_din(din)
    );

    stream_width_downsizer #(.IN_WIDTH(48), .RATIO(3), .LSB_FIRST(1'b0)) u_dut3 (
        .clk(clk), .reset_n(rst_n), .if_empty_n(empty3), .if_read(rd3),
        .if_dout(dout3), .if_full_n(full3), .if_write(wr3), .if_din(din3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; empty_n = 1'b0; full_n = 1'b1; dout = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        if (rd !== 1'b0)  begin n_fail++; $display("FAIL reset_rd: got %b expected 0", rd); end
        if (wr !== 1'b0)  begin n_fail++; $display("FAIL reset_wr: got %b expected 0", wr); end
        if (din !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h expected 0", din); end
        n_assert += 3;
        @(negedge clk); rst_n = 1'b1; #1;
        if (rd !== 1'b1) begin n_fail++; $display("FAIL release_rd: got %b expected 1", rd); end
        if (wr !== 1'b0) begin n_fail++; $display("FAIL release_wr: got %b expected 0", wr); end
        n_assert += 2;
        @(negedge clk); empty_n = 1'b0; #1;
        if (wr !== 1'b1) begin n_fail++; $display("FAIL first_wr: got %b expected 1", wr); end
        if (din !== 32'h3333_4444) begin n_fail++; $display("FAIL first_din: got %h expected 33334444", din); end
        n_assert += 2;
    endtask

    task automatic test_stream();
        logic [31:0] exp_beats [4];
        logic        exp_rd [5];
        exp_beats = '{32'h3333_4444, 32'h1111_2222, 32'hCCCC_DDDD, 32'hAAAA_BBBB};
        exp_rd    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            empty_n = (c < 3);
            dout    = (c < 2) ? W1 : W2;
            #1;
            if (c < 5 && rd !== exp_rd[c]) begin
                n_fail++; $display("FAIL stream_rd[%0d]: got %b expected %b", c, rd, exp_rd[c]);
            end
            if (c >= 1 && c <= 4) begin
                if (wr !== 1'b1 || din !== exp_beats[c-1]) begin
                    n_fail++; $display("FAIL stream_beat[%0d]: got wr=%b din=%h expected wr=1 din=%h", c-1, wr, din, exp_beats[c-1]);
                end
                n_assert++;
            end
            if (c < 5) n_assert++;
            if (c == 5) chk("stream_idle_wr", {63'd0, wr}, 64'd0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk); empty_n = 1'b1; dout = W1; #1;
        chk("bp_load_rd", {63'd0, rd}, 64'd1);
        @(negedge clk); dout = W2; #1;
        chk("bp_beat0", {32'd0, din}, 64'h3333_4444);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); full_n = 1'b0; #1;
            if (wr !== 1'b1 || din !== 32'h1111_2222 || rd !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got wr=%b din=%h rd=%b expected wr=1 din=11112222 rd=0", c, wr, din, rd);
            end
            n_assert++;
        end
        @(negedge clk); full_n = 1'b1; #1;
        chk("bp_resume_din", {32'd0, din}, 64'h1111_2222);
        chk("bp_resume_rd", {63'd0, rd}, 64'd1);
        @(negedge clk); empty_n = 1'b0; #1;
        chk("bp_next_word", {32'd0, din}, 64'hCCCC_DDDD);
        @(negedge clk); #1;
        chk("bp_next_beat1", {32'd0, din}, 64'hAAAA_BBBB);
    endtask

    task automatic test_starvation();
        do_reset();
        @(negedge clk); empty_n = 1'b1; dout = W1; #1;
        @(negedge clk); empty_n = 1'b0; #1;
        chk("starve_beat0", {32'd0, din}, 64'h3333_4444);
        @(negedge clk); #1;
        chk("starve_beat1", {32'd0, din}, 64'h1111_2222);
        chk("starve_last_rd", {63'd0, rd}, 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            if (wr !== 1'b0) begin n_fail++; $display("FAIL starve_empty[%0d]: got wr=%b expected 0", c, wr); end
            n_assert++;
        end
        @(negedge clk); empty_n = 1'b1; dout = W2; #1;
        chk("starve_pop_now", {63'd0, rd}, 64'd1);
        @(negedge clk); empty_n = 1'b0; #1;
        chk("starve_w2_beat0", {32'd0, din}, 64'hCCCC_DDDD);
        @(negedge clk); #1;
        @(negedge clk); #1;
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk); empty_n = 1'b1; dout = W1; #1;
        @(negedge clk); empty_n = 1'b0; #1;
        chk("arst_beat0", {32'd0, din}, 64'h3333_4444);
        @(negedge clk); full_n = 1'b0; #1;
        chk("arst_pending", {32'd0, din}, 64'h1111_2222);
        #2 rst_n = 1'b0;
        #1;
        if (wr !== 1'b0 || din !== 32'h0 || rd !== 1'b0) begin
            n_fail++; $display("FAIL arst_clear: got wr=%b din=%h rd=%b expected all 0", wr, din, rd);
        end
        n_assert++;
        full_n = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (wr !== 1'b0) begin n_fail++; $display("FAIL arst_dropped[%0d]: got wr=%b expected 0", c, wr); end
            n_assert++;
        end
    endtask

    task automatic test_random_ratio3();
        logic [47:0] words[$];
        logic [15:0] exp_q[$];
        logic [47:0] w;
        logic [15:0] e;
        int k, cyc, gaps;
        bit started;
        for (int i = 0; i < N_RAND + N_CONT; i++) begin
            w = {16'($urandom), 32'($urandom)};
            words.push_back(w);
            exp_q.push_back(w[47:32]);
            exp_q.push_back(w[31:16]);
            exp_q.push_back(w[15:0]);
        end
        k = 0; cyc = 0;
        while ((k < N_RAND || exp_q.size() > 3 * N_CONT) && cyc < 60000) begin
            @(negedge clk);
            empty3 = (k < N_RAND) && ($urandom_range(0, 3) != 0);
            dout3  = (k < N_RAND) ? words[k] : 48'd0;
            full3  = ($urandom_range(0, 3) != 0);
            #1;
            if (rd3 && !empty3) begin
                n_fail++; $display("FAIL rand_pop_when_empty: got rd=1 expected 0 at cycle %0d", cyc);
            end
            if (wr3 && full3) begin
                e = exp_q.pop_front();
                n_assert++;
                if (din3 !== e) begin
                    n_fail++; $display("FAIL rand_beat: got %h expected %h at cycle %0d", din3, e, cyc);
                end
            end
            if (rd3) k++;
            cyc++;
        end
        chk("rand_drained", 64'(exp_q.size()), 64'(3 * N_CONT));
        gaps = 0; started = 1'b0; cyc = 0;
        while (exp_q.size() > 0 && cyc < 1000) begin
            @(negedge clk);
            empty3 = (k < N_RAND + N_CONT);
            dout3  = empty3 ? words[k] : 48'd0;
            full3  = 1'b1;
            #1;
            if (wr3) begin
                started = 1'b1;
                e = exp_q.pop_front();
                n_assert++;
                if (din3 !== e) begin
                    n_fail++; $display("FAIL cont_beat: got %h expected %h", din3, e);
                end
            end else if (started) begin
                gaps++;
            end
            if (rd3) k++;
            cyc++;
        end
        chk("cont_gaps", 64'(gaps), 64'd0);
        chk("cont_drained", 64'(exp_q.size()), 64'd0);
        empty3 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; empty_n = 1'b1; full_n = 1'b1; dout = W1;
        empty3 = 1'b0; full3 = 1'b0; dout3 = '0;
        #1 rst_n = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_starvation();
        test_async_reset();
        test_random_ratio3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
